// File: rtl/pingpong_blk_writer.sv
// Write side of the ping/pong sub-block buffer: fills banks a/b from a stream and owns the pingpong token.
// Optional build macro BANK_ZERO_ON_RELEASE_EN clears a released bank's slots and indices.
module pingpong_blk_writer #(
   parameter int SUB_BLK_BIT = 8,
   parameter int SFT_BIT     = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [SFT_BIT-1:0]        start_sft,
   input  logic [SUB_BLK_BIT-1:0]    subBlki,
   input  logic                      subBlki_valid,
   input  logic                      subBlki_last,
   output logic                      subBlki_ready,
   input  logic                      rd_release,
   output logic                      pingpong,
   output logic [16*SUB_BLK_BIT-1:0] aBank,
   output logic [16*SUB_BLK_BIT-1:0] bBank,
   output logic                      aFull,
   output logic                      bFull,
   output logic                      aNeedPang,
   output logic                      bNeedPang,
   output logic [SFT_BIT-1:0]        aNeedPangStartInc,
   output logic [SFT_BIT-1:0]        bNeedPangStartInc,
   output logic [SFT_BIT-1:0]        aNeedPangEndInc,
   output logic [SFT_BIT-1:0]        bNeedPangEndInc,
   output logic                      rel_err
);

   typedef enum logic [1:0] {IDLE, FILL, WAIT_BANK} state_t;

   // Bank index 1 = a, 0 = b, matching the pingpong token encoding.
   state_t                        r_state;
   logic                          r_wr_bank;
   logic [SFT_BIT-1:0]            r_wr_idx;
   logic                          r_pingpong;
   logic                          r_ready;
   logic                          r_rel_err;
   logic                          r_pend;
   logic [SFT_BIT-1:0]            r_pend_sft;
   logic [15:0][SUB_BLK_BIT-1:0]  r_bank [2];
   logic [1:0]                    r_full;
   logic [1:0]                    r_need;
   logic [SFT_BIT-1:0]            r_sinc [2];
   logic [SFT_BIT-1:0]            r_einc [2];

   logic                          w_rel_ok;
   logic                          w_rel_err;
   logic [1:0]                    w_free;
   logic                          w_accept;
   logic                          w_go;
   logic [SFT_BIT-1:0]            w_sft;
   logic                          w_sel;
   logic                          w_last_slot;

   assign w_rel_ok    = rd_release && r_full[r_pingpong];
   assign w_rel_err   = rd_release && !r_full[r_pingpong];
   // A bank released this cycle counts as free so the writer resumes one cycle after the release.
   assign w_free[1]   = !r_full[1] || (w_rel_ok && r_pingpong);
   assign w_free[0]   = !r_full[0] || (w_rel_ok && !r_pingpong);
   assign w_accept    = (r_state == FILL) && r_ready && subBlki_valid;
   assign w_go        = start || r_pend;
   assign w_sft       = start ? start_sft : r_pend_sft;
   assign w_sel       = w_free[1];
   assign w_last_slot = (r_wr_idx == SFT_BIT'(15));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_wr_bank  <= 1'b1;
         r_wr_idx   <= '0;
         r_pingpong <= 1'b1;
         r_ready    <= 1'b0;
         r_rel_err  <= 1'b0;
         r_pend     <= 1'b0;
         r_pend_sft <= '0;
         r_full     <= '0;
         r_need     <= '0;
         for (int unsigned k = 0; k < 2; k++) begin
            r_bank[k] <= '0;
            r_sinc[k] <= '0;
            r_einc[k] <= '0;
         end
      end else begin
         r_rel_err <= w_rel_err;
         // Release bookkeeping comes first so writer updates in the same cycle take precedence.
         if (w_rel_ok) begin
            r_full[r_pingpong] <= 1'b0;
            r_need[r_pingpong] <= 1'b0;
            r_pingpong         <= !r_pingpong;
`ifdef BANK_ZERO_ON_RELEASE_EN
            r_bank[r_pingpong] <= '0;
            r_sinc[r_pingpong] <= '0;
            r_einc[r_pingpong] <= '0;
`endif
         end
         case (r_state)
            IDLE: begin
               if (w_go) begin
                  if (w_free[1] || w_free[0]) begin
                     r_wr_bank      <= w_sel;
                     r_wr_idx       <= w_sft;
                     r_sinc[w_sel]  <= w_sft;
                     r_pend         <= 1'b0;
                     r_state        <= FILL;
                     r_ready        <= 1'b1;
                  end else if (start) begin
                     r_pend     <= 1'b1;
                     r_pend_sft <= start_sft;
                  end
               end
            end
            FILL: begin
               if (w_accept) begin
                  r_bank[r_wr_bank][r_wr_idx] <= subBlki;
                  if (subBlki_last) begin
                     r_full[r_wr_bank] <= 1'b1;
                     r_need[r_wr_bank] <= 1'b0;
                     r_einc[r_wr_bank] <= r_wr_idx;
                     r_state           <= IDLE;
                     r_ready           <= 1'b0;
                  end else if (w_last_slot) begin
                     r_full[r_wr_bank]  <= 1'b1;
                     r_need[r_wr_bank]  <= 1'b1;
                     r_einc[r_wr_bank]  <= SFT_BIT'(15);
                     r_wr_bank          <= !r_wr_bank;
                     r_wr_idx           <= '0;
                     r_sinc[!r_wr_bank] <= '0;
                     if (!w_free[!r_wr_bank]) begin
                        r_state <= WAIT_BANK;
                        r_ready <= 1'b0;
                     end
                  end else begin
                     r_wr_idx <= r_wr_idx + SFT_BIT'(1);
                  end
               end
            end
            WAIT_BANK: begin
               if (w_free[r_wr_bank]) begin
                  r_state <= FILL;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign subBlki_ready     = r_ready;
   assign pingpong          = r_pingpong;
   assign rel_err           = r_rel_err;
   assign aBank             = r_bank[1];
   assign bBank             = r_bank[0];
   assign aFull             = r_full[1];
   assign bFull             = r_full[0];
   assign aNeedPang         = r_need[1];
   assign bNeedPang         = r_need[0];
   assign aNeedPangStartInc = r_sinc[1];
   assign bNeedPangStartInc = r_sinc[0];
   assign aNeedPangEndInc   = r_einc[1];
   assign bNeedPangEndInc   = r_einc[0];

endmodule

// File: tb/tb_pingpong_blk_writer.sv
// Directed bench for pingpong_blk_writer; expectations are hand-computed constants.
module tb_pingpong_blk_writer;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [3:0]   start_sft;
   logic [7:0]   subBlki;
   logic         subBlki_valid;
   logic         subBlki_last;
   logic         subBlki_ready;
   logic         rd_release;
   logic         pingpong;
   logic [127:0] aBank;
   logic [127:0] bBank;
   logic         aFull, bFull, aNeedPang, bNeedPang;
   logic [3:0]   aNeedPangStartInc, bNeedPangStartInc, aNeedPangEndInc, bNeedPangEndInc;
   logic         rel_err;

   int n_assert = 0;
   int n_fail   = 0;

   logic [127:0] exp_s1;
   logic [127:0] exp_b;

   pingpong_blk_writer #(.SUB_BLK_BIT(8), .SFT_BIT(4)) dut (
      .clk(clk), .reset(reset), .start(start), .start_sft(start_sft),
      .subBlki(subBlki), .subBlki_valid(subBlki_valid), .subBlki_last(subBlki_last),
      .subBlki_ready(subBlki_ready), .rd_release(rd_release), .pingpong(pingpong),
      .aBank(aBank), .bBank(bBank), .aFull(aFull), .bFull(bFull),
      .aNeedPang(aNeedPang), .bNeedPang(bNeedPang),
      .aNeedPangStartInc(aNeedPangStartInc), .bNeedPangStartInc(bNeedPangStartInc),
      .aNeedPangEndInc(aNeedPangEndInc), .bNeedPangEndInc(bNeedPangEndInc),
      .rel_err(rel_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [3:0] s);
      start = 1'b1;
      start_sft = s;
      cyc();
      start = 1'b0;
      chk("start_ready", 128'(subBlki_ready), 128'(1));
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      subBlki = d;
      subBlki_last = l;
      subBlki_valid = 1'b1;
      for (int n = 0; n < 20 && !subBlki_ready; n++) cyc();
      chk("beat_ready", 128'(subBlki_ready), 128'(1));
      cyc();
      subBlki_valid = 1'b0;
      subBlki_last = 1'b0;
   endtask

   task automatic release_bank();
      rd_release = 1'b1;
      cyc();
      rd_release = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; start_sft = '0; subBlki = '0;
      subBlki_valid = 1'b0; subBlki_last = 1'b0; rd_release = 1'b0;
      for (int i = 0; i < 16; i++) exp_s1[i*8 +: 8] = 8'(i + 1);
      for (int i = 0; i < 16; i++) exp_b[i*8 +: 8]  = 8'(i + 17);
      cyc(); cyc();
      chk("rst_pingpong", 128'(pingpong), 128'(1));
      chk("rst_ready",    128'(subBlki_ready), 128'(0));
      chk("rst_full",     128'({aFull, bFull, aNeedPang, bNeedPang}), 128'(0));
      chk("rst_aBank",    aBank, 128'(0));
      chk("rst_bBank",    bBank, 128'(0));
      chk("rst_rel_err",  128'(rel_err), 128'(0));
      reset = 1'b0;
      cyc();

      // Release against an empty bank a
      release_bank();
      chk("relerr_pulse", 128'(rel_err), 128'(1));
      chk("relerr_pp",    128'(pingpong), 128'(1));
      chk("relerr_full",  128'({aFull, bFull}), 128'(0));
      cyc();
      chk("relerr_clear", 128'(rel_err), 128'(0));

      // Scenario 1: full bank a from slot 0
      do_start(4'd0);
      for (int i = 1; i <= 16; i++) send(8'(i), i == 16);
      chk("s1_aBank", aBank, exp_s1);
      chk("s1_aFull", 128'(aFull), 128'(1));
      chk("s1_bFull", 128'(bFull), 128'(0));
      chk("s1_aNeed", 128'(aNeedPang), 128'(0));
      chk("s1_aStart", 128'(aNeedPangStartInc), 128'(0));
      chk("s1_aEnd",  128'(aNeedPangEndInc), 128'(15));
      chk("s1_pp",    128'(pingpong), 128'(1));
      chk("s1_ready", 128'(subBlki_ready), 128'(0));
      release_bank();
      chk("s1rel_aFull", 128'(aFull), 128'(0));
      chk("s1rel_pp",    128'(pingpong), 128'(0));
      chk("s1rel_err",   128'(rel_err), 128'(0));
`ifdef BANK_ZERO_ON_RELEASE_EN
      chk("s1rel_aBank", aBank, 128'(0));
      chk("s1rel_aEnd",  128'(aNeedPangEndInc), 128'(0));
`else
      chk("s1rel_aBank", aBank, exp_s1);
      chk("s1rel_aEnd",  128'(aNeedPangEndInc), 128'(15));
`endif

      // Scenario 2: offset 12 spilling into bank b
      do_start(4'd12);
      for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), i == 5);
      chk("s2_aHi",     128'(aBank[127:96]), 128'(32'hA3A2A1A0));
      chk("s2_aNeed",   128'(aNeedPang), 128'(1));
      chk("s2_aStart",  128'(aNeedPangStartInc), 128'(12));
      chk("s2_aEnd",    128'(aNeedPangEndInc), 128'(15));
      chk("s2_bLo",     128'(bBank[15:0]), 128'(16'hA5A4));
      chk("s2_bNeed",   128'(bNeedPang), 128'(0));
      chk("s2_bStart",  128'(bNeedPangStartInc), 128'(0));
      chk("s2_bEnd",    128'(bNeedPangEndInc), 128'(1));
      chk("s2_full",    128'({aFull, bFull}), 128'(2'b11));
      release_bank();
      chk("s2relb_full", 128'({aFull, bFull}), 128'(2'b10));
      chk("s2relb_pp",   128'(pingpong), 128'(1));
      release_bank();
      chk("s2rela_full", 128'({aFull, aNeedPang}), 128'(0));
      chk("s2rela_pp",   128'(pingpong), 128'(0));

      // Scenario 5: reset in the middle of a fill at wr_idx 7
      do_start(4'd0);
      for (int i = 0; i < 7; i++) send(8'h51 + 8'(i), 1'b0);
      #3 reset = 1'b1;
      #1;
      chk("mrst_aBank", aBank, 128'(0));
      chk("mrst_ready", 128'(subBlki_ready), 128'(0));
      chk("mrst_pp",    128'(pingpong), 128'(1));
      chk("mrst_flags", 128'({aFull, bFull, aNeedPang, bNeedPang, aNeedPangStartInc, aNeedPangEndInc}), 128'(0));
      cyc();
      reset = 1'b0;
      cyc();

      // Scenario 3: fill a and b, stall in WAIT_BANK, resume after release
      do_start(4'd0);
      for (int i = 1; i <= 16; i++) send(8'(i), 1'b0);
      chk("s3_aBank",  aBank, exp_s1);
      chk("s3_aNeed",  128'({aFull, aNeedPang}), 128'(2'b11));
      chk("s3_aEnd",   128'(aNeedPangEndInc), 128'(15));
      chk("s3_ready",  128'(subBlki_ready), 128'(1));
      for (int i = 17; i <= 32; i++) send(8'(i), 1'b0);
      chk("s3_wait_ready", 128'(subBlki_ready), 128'(0));
      chk("s3_bBank",  bBank, exp_b);
      chk("s3_bFlags", 128'({bFull, bNeedPang}), 128'(2'b11));
      subBlki = 8'd33; subBlki_valid = 1'b1;
      cyc();
      chk("s3_hold_ready", 128'(subBlki_ready), 128'(0));
      release_bank();
      chk("s3_resume_ready", 128'(subBlki_ready), 128'(1));
      chk("s3_resume_full",  128'({aFull, bFull}), 128'(2'b01));
      chk("s3_resume_pp",    128'(pingpong), 128'(0));
      for (int i = 33; i <= 36; i++) send(8'(i), i == 36);
      chk("s3_aLo",    128'(aBank[31:0]), 128'(32'h24232221));
`ifdef BANK_ZERO_ON_RELEASE_EN
      chk("s3_aHi",    128'(aBank[127:32]), 128'(0));
`else
      chk("s3_aHi",    128'(aBank[127:32]), 128'(exp_s1[127:32]));
`endif
      chk("s3_aFlags", 128'({aFull, aNeedPang}), 128'(2'b10));
      chk("s3_aIdx",   128'({aNeedPangStartInc, aNeedPangEndInc}), 128'(8'h03));
      chk("s3_end_ready", 128'(subBlki_ready), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pingpong_blk_writer.md
Name: pingpong_blk_writer

Overview:
Write side of the ping/pong sub-block buffer. It accepts a stream of sub-blocks and places them into two 16-slot banks (a = ping, b = pong), starting at a programmable slot offset. It publishes bank contents, full flags and per-bank needPang/start/end indices to the shifting reader. It owns the pingpong token, which tells the reader which bank to consume (1 = a, 0 = b), and toggles that token when the reader releases a bank.

Parameters:
SUB_BLK_BIT, 8, width of one sub-block (matches `SUB_BLK_BIT)
SFT_BIT, 4, slot index width; bank depth is fixed at 16 (matches `SFT_BIT)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
start_sft  in  SFT_BIT  first slot written in the first bank of a frame; sampled with start
subBlki  in  SUB_BLK_BIT  incoming sub-block
subBlki_valid  in  1  subBlki is valid this cycle
subBlki_last  in  1  qualifies subBlki as the final beat of the frame
subBlki_ready  out  1  writer accepts subBlki this cycle
rd_release  in  1  reader has finished the bank selected by pingpong
pingpong  out  1  bank for the reader to consume: 1 = a, 0 = b
aBank  out  16*SUB_BLK_BIT  slots a00..a15; slot i at bits [i*SUB_BLK_BIT +: SUB_BLK_BIT]
bBank  out  16*SUB_BLK_BIT  slots b00..b15, same layout
aFull, bFull  out  1  bank closed and ready for the reader
aNeedPang, bNeedPang  out  1  frame continues into the other bank
aNeedPangStartInc, bNeedPangStartInc  out  SFT_BIT  first valid slot in the bank
aNeedPangEndInc, bNeedPangEndInc  out  SFT_BIT  last valid slot in the bank
rel_err  out  1  one-cycle pulse: rd_release arrived while the selected bank was not full

Behaviour:
- Reset (asynchronous): FSM = IDLE; wr_bank = a; wr_idx = 0; pingpong = 1; all bank slots = 0; full, needPang, StartInc, EndInc = 0; subBlki_ready = 0; rel_err = 0.
- States:
  - IDLE: ready = 0. On start, select the free bank (prefer a if both are free), set wr_idx = start_sft, latch that bank's StartInc = start_sft, go to FILL. If start arrives with no free bank, stay in IDLE and remember the start pending; move to FILL as soon as a bank frees.
  - FILL: ready = 1. A beat is accepted when valid && ready. The slot is written and becomes visible on the bank bus the next cycle; then wr_idx increments.
    - Accepted beat with last = 1: close the bank (full = 1, EndInc = wr_idx, needPang = 0) and go to IDLE.
    - Accepted beat at wr_idx = 15 with last = 0: close the bank (full = 1, EndInc = 15, needPang = 1), switch wr_bank, wr_idx = 0, other bank's StartInc = 0. If the other bank is full, go to WAIT_BANK.
  - WAIT_BANK: ready = 0. When the target bank frees, go to FILL the following cycle.
- Full flags assert the cycle after the closing beat. Every bank is closed through exactly one of these two paths.
- Release: rd_release with the selected bank full clears that bank's full and needPang flags and toggles pingpong, both on the next edge. rd_release with the selected bank not full is ignored and pulses rel_err.
- Simultaneous release and close: the reader only releases the full bank and the writer only fills the non-full bank, so both take effect in the same cycle without conflict.
- A release in the same cycle as WAIT_BANK exit: ready rises exactly one cycle after the release.
- start in FILL or WAIT_BANK is ignored.
- wr_idx is SFT_BIT bits and wraps 15 -> 0 only through the bank switch.
- start_sft = 15 with last on the first beat: a one-slot bank with StartInc = EndInc = 15.

Optional Feature:
BANK_ZERO_ON_RELEASE_EN
- Defined: on a valid release, all 16 slots of the released bank are cleared to 0, along with StartInc and EndInc.
- Undefined: slot data and indices persist until overwritten. Only the full and needPang flags clear.

Test Plan:
- Reset, then start (start_sft = 0), 16 beats 0x01..0x10 with last on the 16th -> aBank slot i = i+1; aFull = 1; aNeedPang = 0; Start/End = 0/15; pingpong = 1.
- start_sft = 12, 6 beats 0xA0..0xA5 with last on the 6th -> a slots 12..15 = A0..A3; aNeedPang = 1 with Start/End = 12/15; b slots 0..1 = A4,A5; bNeedPang = 0 with Start/End = 0/1.
- Fill a and b fully (36 beats offered, last on beat 36) with no release -> ready drops after beat 32; WAIT_BANK; rd_release; ready = 1 the next cycle; beats 33..36 land in a slots 0..3.
- rd_release with aFull = 0 -> rel_err pulses one cycle; pingpong and flags unchanged.
- Assert reset mid-FILL at wr_idx = 7 -> all outputs return to reset values immediately; a new start behaves as in scenario 1.
- With BANK_ZERO_ON_RELEASE_EN: release a full bank a -> aBank = 0 the next cycle. Without the macro -> aBank data retained, aFull = 0.
